// File: rtl/wb_data_master_pkg.sv
// Shared definitions for the data-port Wishbone master: reset level,
// zero word, pipeline stall bit index and the bus FSM state encoding.
package wb_data_master_pkg;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam int          MEM_STALL_BIT = 3;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'b00,
        WB_BUSY       = 2'b01,
        WB_WAIT_STALL = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_data_master_if.sv
// Wishbone classic bus between the CPU data master and the peripheral decoder.
// Signal suffixes are from the master's point of view.
interface wb_data_master_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_data_master.sv
// CPU data-port Wishbone master. Turns a MEM-stage load/store into one
// classic Wishbone cycle, stalls the pipeline until it terminates and
// returns load data. One transaction in flight, no bursts. A watchdog
// aborts a cycle the slave never acknowledges (TIMEOUT = 0 disables it;
// TO_W must be wide enough that 2**TO_W > TIMEOUT).
module wb_data_master
    import wb_data_master_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        bus_err_o,
    wb_data_master_if.master wb
);

    localparam bit             WDOG_EN = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    wb_state_e       state_q;
    wb_state_e       state_d;
    logic            cyc_q;
    logic            we_q;
    logic [31:0]     adr_q;
    logic [3:0]      sel_q;
    logic [31:0]     dat_q;
    logic [31:0]     rd_buf_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            bus_err_q;
    logic            stall_mem;
    logic            timeout_hit;
    logic            start_req;

    // Only the MEM-stage bit of the stall vector matters here.
    assign stall_mem = stall_i[MEM_STALL_BIT];
    wire unused_stall = &{1'b0, stall_i[5:4], stall_i[2:0]};

    assign start_req   = cpu_ce_i && !flush_i;
    assign timeout_hit = WDOG_EN && (to_cnt_q == TO_LAST);

    // cyc and stb come from the same flop so they can never disagree.
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_dat_o = dat_q;
    assign bus_err_o   = bus_err_q;

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        // NOTE: non-blocking (<=) on every flop so all registers update from pre-edge values together.
        if (wb_rst_i == RST_ENABLE) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush beats ack, ack beats the watchdog.
    always_comb begin
        // NOTE: default every comb output first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (start_req) state_d = WB_BUSY;
            end
            WB_BUSY: begin
                if (flush_i)          state_d = WB_IDLE;
                else if (wb.wb_ack_i) state_d = stall_mem ? WB_WAIT_STALL : WB_IDLE;
                else if (timeout_hit) state_d = WB_IDLE;
            end
            WB_WAIT_STALL: begin
                if (!stall_mem || flush_i) state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Pipeline-facing outputs: stall request and load data.
    always_comb begin
        stall_req_o = 1'b0;
        cpu_data_o  = ZERO_WORD;
        case (state_q)
            WB_IDLE: begin
                stall_req_o = start_req;
            end
            WB_BUSY: begin
                if (!flush_i) begin
                    if (wb.wb_ack_i) begin
                        if (!we_q) cpu_data_o = wb.wb_dat_i;
                    end else begin
                        stall_req_o = 1'b1;
                    end
                end
            end
            WB_WAIT_STALL: begin
                // Hold the captured load data while another stage keeps the pipe frozen.
                cpu_data_o = rd_buf_q;
            end
            default: ;
        endcase
    end

    // Registered bus outputs, read-data buffer, watchdog counter and error pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (wb_rst_i == RST_ENABLE) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= ZERO_WORD;
            sel_q     <= 4'h0;
            dat_q     <= ZERO_WORD;
            rd_buf_q  <= ZERO_WORD;
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (start_req) begin
                        cyc_q    <= 1'b1;
                        we_q     <= cpu_we_i;
                        adr_q    <= cpu_addr_i;
                        sel_q    <= cpu_sel_i;
                        dat_q    <= cpu_data_i;
                        to_cnt_q <= '0;
                    end
                end
                WB_BUSY: begin
                    if (flush_i) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                    end else if (wb.wb_ack_i) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (!we_q) rd_buf_q <= wb.wb_dat_i;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                        if (timeout_hit) begin
                            cyc_q     <= 1'b0;
                            we_q      <= 1'b0;
                            bus_err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_data_master.sv
// Directed bench for wb_data_master with a small Wishbone slave model
// (LED register, switch input, programmable ack delay, dead-slave mode).
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_wb_data_master;

    localparam logic [31:0] LED_ADDR = 32'hBFD0_F000;
    localparam logic [31:0] SW_ADDR  = 32'hBFD0_F020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [5:0]  stall;
    logic        flush;
    logic        stall_req;
    logic        bus_err;

    wb_data_master_if wb ();

    wb_data_master #(.TIMEOUT(4), .TO_W(3)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .cpu_ce_i    (cpu_ce),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_sel_i   (cpu_sel),
        .cpu_data_i  (cpu_wdata),
        .cpu_data_o  (cpu_rdata),
        .stall_i     (stall),
        .flush_i     (flush),
        .stall_req_o (stall_req),
        .bus_err_o   (bus_err),
        .wb          (wb)
    );

    always #5 clk = ~clk;

    // Slave model.
    int          ack_wait   = 0;
    logic        slave_dead = 1'b0;
    logic [7:0]  switch_val = 8'h00;
    logic [31:0] led_reg;
    int          wait_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            led_reg  <= 32'h0;
        end else begin
            if (wb.wb_cyc_o && !wb.wb_ack_i) wait_cnt <= wait_cnt + 1;
            else                             wait_cnt <= 0;
            if (wb.wb_ack_i && wb.wb_we_o && wb.wb_adr_o == LED_ADDR) led_reg <= wb.wb_dat_o;
        end
    end

    assign wb.wb_ack_i = wb.wb_cyc_o && wb.wb_stb_o && !slave_dead && (wait_cnt >= ack_wait);
    assign wb.wb_dat_i = (wb.wb_adr_o == SW_ADDR) ? {24'h0, switch_val} : 32'h1234_5678;

    // Per-cycle activity counters, sampled at the end of each cycle.
    int   cyc_hi   = 0;
    int   cyc_rise = 0;
    int   stall_hi = 0;
    int   err_hi   = 0;
    logic cyc_prev = 1'b0;

    always @(posedge clk) begin
        if (wb.wb_cyc_o) cyc_hi <= cyc_hi + 1;
        if (wb.wb_cyc_o && !cyc_prev) cyc_rise <= cyc_rise + 1;
        cyc_prev <= wb.wb_cyc_o;
        if (stall_req) stall_hi <= stall_hi + 1;
        if (bus_err) err_hi <= err_hi + 1;
    end

    int b_cyc, b_rise, b_stall, b_err;
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic snap();
        b_cyc   = cyc_hi;
        b_rise  = cyc_rise;
        b_stall = stall_hi;
        b_err   = err_hi;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_ce    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_sel   = 4'h0;
        cpu_wdata = 32'h0;
        stall     = 6'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_bit("rst_cyc", wb.wb_cyc_o, 1'b0);
        check_bit("rst_stb", wb.wb_stb_o, 1'b0);
        check_bit("rst_we", wb.wb_we_o, 1'b0);
        check("rst_adr", wb.wb_adr_o, 32'h0);
        check("rst_dat", wb.wb_dat_o, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check_bit("rst_stall", stall_req, 1'b0);
        check_bit("rst_err", bus_err, 1'b0);
        rst_n = 1'b1;

        // 1: store to LED, zero-wait slave.
        next_cycle();
        snap();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = LED_ADDR; cpu_sel = 4'hF; cpu_wdata = 32'h0000_A5A5;
        mid();
        check_bit("t1_req_stall", stall_req, 1'b1);
        check_bit("t1_idle_cyc", wb.wb_cyc_o, 1'b0);
        next_cycle();
        mid();
        check_bit("t1_cyc", wb.wb_cyc_o, 1'b1);
        check_bit("t1_stb", wb.wb_stb_o, 1'b1);
        check_bit("t1_we", wb.wb_we_o, 1'b1);
        check("t1_adr", wb.wb_adr_o, LED_ADDR);
        check("t1_dat", wb.wb_dat_o, 32'h0000_A5A5);
        check("t1_sel", {28'h0, wb.wb_sel_o}, 32'hF);
        check_bit("t1_ack_stall", stall_req, 1'b0);
        next_cycle();
        idle_inputs();
        mid();
        check_bit("t1_cyc_drop", wb.wb_cyc_o, 1'b0);
        check_bit("t1_we_drop", wb.wb_we_o, 1'b0);
        check("t1_led", led_reg, 32'h0000_A5A5);
        check("t1_cyc_cycles", cyc_hi - b_cyc, 32'd1);
        check("t1_stall_cycles", stall_hi - b_stall, 32'd1);

        // 2: load from switches, zero-wait; non-MEM stall bits are ignored.
        next_cycle();
        snap();
        switch_val = 8'h3C;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = SW_ADDR; cpu_sel = 4'hF;
        mid();
        check("t2_idle_rdata", cpu_rdata, 32'h0);
        check_bit("t2_req_stall", stall_req, 1'b1);
        next_cycle();
        stall = 6'b110111;
        mid();
        check("t2_ack_rdata", cpu_rdata, 32'h0000_003C);
        check_bit("t2_ack_stall", stall_req, 1'b0);
        check_bit("t2_we", wb.wb_we_o, 1'b0);
        next_cycle();
        idle_inputs();
        mid();
        check("t2_after_rdata", cpu_rdata, 32'h0);
        check("t2_one_cycle", cyc_rise - b_rise, 32'd1);

        // 3: ack after 3 wait cycles (at the last watchdog count), then MEM stall held.
        next_cycle();
        snap();
        ack_wait = 3;
        switch_val = 8'h5A;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = SW_ADDR; cpu_sel = 4'hF;
        mid();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            mid();
            check_bit("t3_wait_stall", stall_req, 1'b1);
            check_bit("t3_wait_cyc", wb.wb_cyc_o, 1'b1);
            check("t3_wait_rdata", cpu_rdata, 32'h0);
        end
        next_cycle();
        stall = 6'b001000;
        mid();
        check("t3_ack_rdata", cpu_rdata, 32'h0000_005A);
        check_bit("t3_ack_stall", stall_req, 1'b0);
        next_cycle();
        switch_val = 8'hFF;
        mid();
        check_bit("t3_ws_cyc", wb.wb_cyc_o, 1'b0);
        check_bit("t3_no_abort", bus_err, 1'b0);
        check("t3_ws_rdata", cpu_rdata, 32'h0000_005A);
        check_bit("t3_ws_stall", stall_req, 1'b0);
        next_cycle();
        mid();
        check("t3_ws_hold", cpu_rdata, 32'h0000_005A);
        next_cycle();
        stall = 6'b0;
        mid();
        check("t3_ws_last", cpu_rdata, 32'h0000_005A);
        next_cycle();
        idle_inputs();
        mid();
        check("t3_idle_rdata", cpu_rdata, 32'h0);
        check("t3_single_cyc", cyc_rise - b_rise, 32'd1);
        check("t3_cyc_cycles", cyc_hi - b_cyc, 32'd4);
        check("t3_no_err", err_hi - b_err, 32'd0);
        ack_wait = 0;

        // 4: flush in the second BUSY cycle, same cycle as ack.
        next_cycle();
        snap();
        ack_wait = 1;
        switch_val = 8'h3C;
        cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = SW_ADDR; cpu_sel = 4'hF;
        mid();
        next_cycle();
        mid();
        check_bit("t4_busy_stall", stall_req, 1'b1);
        next_cycle();
        flush = 1'b1;
        stall = 6'b001000;
        mid();
        check_bit("t4_flush_stall", stall_req, 1'b0);
        check("t4_flush_rdata", cpu_rdata, 32'h0);
        next_cycle();
        idle_inputs();
        stall = 6'b001000;
        mid();
        check_bit("t4_cyc_drop", wb.wb_cyc_o, 1'b0);
        check("t4_no_wait_stall", cpu_rdata, 32'h0);
        check("t4_single_cyc", cyc_rise - b_rise, 32'd1);
        stall = 6'b0;
        ack_wait = 0;

        // 5: dead slave, watchdog abort after 4 BUSY cycles.
        next_cycle();
        snap();
        slave_dead = 1'b1;
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = LED_ADDR; cpu_sel = 4'hF; cpu_wdata = 32'h0000_1111;
        mid();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mid();
            check_bit("t5_busy_cyc", wb.wb_cyc_o, 1'b1);
            check_bit("t5_busy_stall", stall_req, 1'b1);
            check_bit("t5_busy_err", bus_err, 1'b0);
        end
        next_cycle();
        idle_inputs();
        mid();
        check_bit("t5_abort_cyc", wb.wb_cyc_o, 1'b0);
        check_bit("t5_err_pulse", bus_err, 1'b1);
        check_bit("t5_stall_rel", stall_req, 1'b0);
        check("t5_abort_rdata", cpu_rdata, 32'h0);
        next_cycle();
        mid();
        check_bit("t5_err_end", bus_err, 1'b0);
        check("t5_cyc_cycles", cyc_hi - b_cyc, 32'd4);
        check("t5_err_count", err_hi - b_err, 32'd1);
        check("t5_led_kept", led_reg, 32'h0000_A5A5);

        // 6: reset while a cycle is open.
        next_cycle();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = LED_ADDR; cpu_sel = 4'h3; cpu_wdata = 32'h0000_BEEF;
        mid();
        next_cycle();
        mid();
        check_bit("t6_pre_cyc", wb.wb_cyc_o, 1'b1);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_bit("t6_rst_cyc", wb.wb_cyc_o, 1'b0);
        check_bit("t6_rst_stb", wb.wb_stb_o, 1'b0);
        check_bit("t6_rst_we", wb.wb_we_o, 1'b0);
        check("t6_rst_adr", wb.wb_adr_o, 32'h0);
        check("t6_rst_sel", {28'h0, wb.wb_sel_o}, 32'h0);
        check("t6_rst_dat", wb.wb_dat_o, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        slave_dead = 1'b0;
        mid();
        check_bit("t6_rel_cyc", wb.wb_cyc_o, 1'b0);
        check_bit("t6_rel_stall", stall_req, 1'b0);
        next_cycle();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = LED_ADDR; cpu_sel = 4'hF; cpu_wdata = 32'h0000_0F0F;
        mid();
        check_bit("t6_new_stall", stall_req, 1'b1);
        next_cycle();
        mid();
        check_bit("t6_new_cyc", wb.wb_cyc_o, 1'b1);
        check("t6_new_dat", wb.wb_dat_o, 32'h0000_0F0F);
        next_cycle();
        idle_inputs();
        mid();
        check("t6_led", led_reg, 32'h0000_0F0F);
        check_bit("t6_new_drop", wb.wb_cyc_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
